vehicle_request: RTL and testbench

- Upstream stage of the traffic light controller. Produces its country-road request input `x` from a raw stop-line vehicle detector.
- Synchronises and debounces the detector, and keeps a saturating count of waiting vehicles.
- Raises `x` while vehicles wait. Drops `x` when the queue drains or a maximum-green timeout expires, which guarantees the highway gets its turn back.
- Watches the controller's `country` lamp output to tell when vehicles are being served.

---
 rtl/vehicle_request_if.sv | 14 +
 rtl/vehicle_request.sv | 130 +++++++++++++
 tb/tb_vehicle_request.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vehicle_request_if.sv
// rtl/vehicle_request_if.sv - detector/lamp inputs and request outputs of vehicle_request
interface vehicle_request_if #(
  parameter int CNT_W = 4
);
  logic             sensor_raw;
  logic [2:0]       country;
  logic             x;
  logic [CNT_W-1:0] veh_count;
  logic             timeout;
  logic             sensor_fault;

  modport master (output sensor_raw, country, input x, veh_count, timeout, sensor_fault);
  modport slave  (input sensor_raw, country, output x, veh_count, timeout, sensor_fault);
endinterface

// File: rtl/vehicle_request.sv
// rtl/vehicle_request.sv - debounced vehicle detector, waiting-vehicle counter and request FSM
// Optional stuck-detector supervision enabled by defining STUCK_DETECT_EN.
module vehicle_request #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int MAX_GREEN       = 32,
  parameter int STUCK_CYCLES    = 256
) (
  input logic clk,
  input logic rst,
  vehicle_request_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(MAX_GREEN);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0]  TM_LAST = TM_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic             s1, s2, deb, deb_q;
  logic [DB_W-1:0]  db_cnt;
  logic [CNT_W-1:0] veh_count, cnt_nxt;
  logic [TM_W-1:0]  timer;
  logic [1:0]       state, state_nxt;
  logic             x_q, timeout_q, to_nxt;
  logic             green, arrive, depart, fault;

  // Illegal (non one-hot) lamp codes never compare equal to green.
  assign green  = (bus.country == 3'b001);
  assign arrive = deb & ~deb_q;
  assign depart = ~deb & deb_q & green;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      deb    <= 1'b0;
      deb_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1    <= bus.sensor_raw;
      s2    <= s1;
      deb_q <= deb;
      if (s2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb    <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef STUCK_DETECT_EN
  localparam int ST_W = $clog2(STUCK_CYCLES + 1);
  logic [ST_W-1:0] stuck_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_cnt <= '0;
      fault     <= 1'b0;
    end else if (!deb) begin
      stuck_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      if (stuck_cnt != ST_W'(STUCK_CYCLES)) stuck_cnt <= stuck_cnt + 1'b1;
      if (stuck_cnt >= ST_W'(STUCK_CYCLES - 1)) fault <= 1'b1;
    end
  end
`else
  // No stuck supervision in this build; the flag can never assert.
  assign fault = (STUCK_CYCLES < 0);
`endif

  always_comb begin
    cnt_nxt = veh_count;
    if (arrive && veh_count != CNT_MAX)
      cnt_nxt = veh_count + 1'b1;
    else if (depart && veh_count != '0)
      cnt_nxt = veh_count - 1'b1;
    // A stuck detector freezes the queue but keeps at least one request alive.
    if (fault)
      cnt_nxt = (veh_count == '0) ? CNT_W'(1) : veh_count;
  end

  always_comb begin
    state_nxt = state;
    to_nxt    = 1'b0;
    case (state)
      IDLE:  if (veh_count != '0) state_nxt = REQ;
      REQ:   if (green) state_nxt = SERVE;
      SERVE: begin
        if (veh_count == '0) begin
          state_nxt = DRAIN;
        end else if (timer == TM_LAST) begin
          state_nxt = DRAIN;
          to_nxt    = 1'b1;
        end
      end
      DRAIN: if (!green) state_nxt = (veh_count != '0) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      veh_count <= '0;
      state     <= IDLE;
      timer     <= '0;
      x_q       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      veh_count <= cnt_nxt;
      state     <= state_nxt;
      timer     <= (state == SERVE) ? timer + 1'b1 : '0;
      x_q       <= (state_nxt == REQ) || (state_nxt == SERVE);
      timeout_q <= to_nxt;
    end
  end

  assign bus.x            = x_q;
  assign bus.veh_count    = veh_count;
  assign bus.timeout      = timeout_q;
  assign bus.sensor_fault = fault;
endmodule

// File: tb/tb_vehicle_request.sv
// tb/tb_vehicle_request.sv - directed vector table, hand sequences and random model check of vehicle_request
module tb_vehicle_request;
  localparam int DB   = 4;
  localparam int CW   = 4;
  localparam int MG   = 8;
  localparam int CMAX = 15;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vehicle_request_if #(.CNT_W(CW)) bus();

  vehicle_request #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW), .MAX_GREEN(MG), .STUCK_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.sensor_raw = 1'b0;
    bus.country = R;
    @(posedge clk);
    #1;
    chk("rst_x", int'(bus.x), 0);
    chk("rst_cnt", int'(bus.veh_count), 0);
    chk("rst_to", int'(bus.timeout), 0);
    chk("rst_fault", int'(bus.sensor_fault), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_edges(input logic raw, input logic [2:0] c, input int n);
    bus.sensor_raw = raw;
    bus.country = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         do_rst;
    bit         raw;
    logic [2:0] country;
    int         edges;
    bit         ex;
    int         ecnt;
    bit         eto;
  } vec_t;
  vec_t tv[$];

  // Reference model: debounced level flips once its last DB synchroniser samples all disagree.
  bit m_s1, m_s2, m_deb, m_debq;
  bit s2win[$];
  int m_cnt, m_mode, m_serve;
  bit m_x, m_to;

  task automatic m_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_debq = 0;
    s2win.delete();
    m_cnt = 0; m_mode = 0; m_serve = 0; m_x = 0; m_to = 0;
  endtask

  task automatic m_step(input bit raw, input logic [2:0] c);
    bit g, nd, all_diff;
    int nc;
    g  = (c == G);
    nd = m_deb;
    nc = m_cnt;
    s2win.push_back(m_s2);
    if (s2win.size() > DB) void'(s2win.pop_front());
    all_diff = (s2win.size() == DB);
    foreach (s2win[i]) if (s2win[i] == m_deb) all_diff = 0;
    if (all_diff) nd = !m_deb;
    if (m_deb && !m_debq) nc = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    else if (!m_deb && m_debq && g) nc = (m_cnt > 0) ? m_cnt - 1 : 0;
    m_to = 0;
    // modes: 0 quiet, 1 waiting for green, 2 being served, 3 lamp still green after cutoff
    case (m_mode)
      0: if (m_cnt != 0) m_mode = 1;
      1: if (g) begin m_mode = 2; m_serve = 0; end
      2: begin
        m_serve = m_serve + 1;
        if (m_cnt == 0) m_mode = 3;
        else if (m_serve == MG) begin m_mode = 3; m_to = 1; end
      end
      default: if (!g) m_mode = (m_cnt != 0) ? 1 : 0;
    endcase
    m_x = (m_mode == 1) || (m_mode == 2);
    m_debq = m_deb;
    m_deb = nd;
    m_s2 = m_s1;
    m_s1 = raw;
    m_cnt = nc;
  endtask

  initial begin
    bit raw;
    logic [2:0] ctry;
    int raw_hold, c_hold;
    logic [2:0] codes [8];

    bus.sensor_raw = 1'b0;
    bus.country = R;

    // request path, glitch rejection, non-green falls, timeout and re-request
    tv.push_back('{1, 1, R, 5, 0, 0, 0});
    tv.push_back('{0, 1, R, 1, 0, 0, 0});
    tv.push_back('{0, 1, R, 1, 0, 1, 0});
    tv.push_back('{0, 1, R, 1, 1, 1, 0});
    tv.push_back('{0, 0, R, 8, 1, 1, 0});
    tv.push_back('{0, 1, R, 3, 1, 1, 0});
    tv.push_back('{0, 0, R, 8, 1, 1, 0});
    tv.push_back('{0, 1, R, 8, 1, 2, 0});
    tv.push_back('{0, 0, Y, 8, 1, 2, 0});
    tv.push_back('{0, 1, Y, 8, 1, 3, 0});
    tv.push_back('{0, 1, G, 1, 1, 3, 0});
    tv.push_back('{0, 1, G, 7, 1, 3, 0});
    tv.push_back('{0, 1, G, 1, 0, 3, 1});
    tv.push_back('{0, 1, G, 1, 0, 3, 0});
    tv.push_back('{0, 1, R, 1, 1, 3, 0});
    tv.push_back('{0, 1, G, 1, 1, 3, 0});
    tv.push_back('{0, 0, G, 7, 1, 2, 0});
    tv.push_back('{0, 0, G, 1, 0, 2, 1});
    tv.push_back('{0, 0, R, 1, 1, 2, 0});
    // service until empty; empty queue beats the cutoff on the same cycle
    tv.push_back('{1, 1, R, 7, 0, 1, 0});
    tv.push_back('{0, 1, R, 1, 1, 1, 0});
    tv.push_back('{0, 1, G, 1, 1, 1, 0});
    tv.push_back('{0, 0, G, 7, 1, 0, 0});
    tv.push_back('{0, 0, G, 1, 0, 0, 0});
    tv.push_back('{0, 0, Y, 1, 0, 0, 0});
    tv.push_back('{0, 0, R, 3, 0, 0, 0});

    foreach (tv[i]) begin
      if (tv[i].do_rst) reset_dut();
      run_edges(tv[i].raw, tv[i].country, tv[i].edges);
      chk($sformatf("vec%0d_x", i), int'(bus.x), int'(tv[i].ex));
      chk($sformatf("vec%0d_cnt", i), int'(bus.veh_count), tv[i].ecnt);
      chk($sformatf("vec%0d_to", i), int'(bus.timeout), int'(tv[i].eto));
    end

    // saturation: 20 arrivals under red
    reset_dut();
    for (int p = 0; p < 20; p++) begin
      run_edges(1'b1, R, 6);
      run_edges(1'b0, R, 6);
    end
    run_edges(1'b0, R, 4);
    chk("sat_cnt", int'(bus.veh_count), 15);
    chk("sat_x", int'(bus.x), 1);

    // asynchronous reset while serving
    reset_dut();
    run_edges(1'b1, R, 8);
    run_edges(1'b0, G, 1);
    chk("ar_pre_x", int'(bus.x), 1);
    chk("ar_pre_cnt", int'(bus.veh_count), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_x", int'(bus.x), 0);
    chk("ar_cnt", int'(bus.veh_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_edges(1'b0, R, 3);
    chk("ar_idle_x", int'(bus.x), 0);
    chk("ar_idle_cnt", int'(bus.veh_count), 0);

    // randomized traffic against the reference model
    codes = '{R, Y, G, G, G, 3'b000, 3'b011, 3'b111};
    reset_dut();
    m_reset();
    raw = 1'b0;
    ctry = R;
    raw_hold = 3;
    c_hold = 10;
    for (int c = 0; c < 3000; c++) begin
      if (raw_hold == 0) begin
        raw = ~raw;
        raw_hold = $urandom_range(12, 1);
      end
      raw_hold--;
      if (c_hold == 0) begin
        ctry = codes[$urandom_range(7, 0)];
        c_hold = $urandom_range(25, 1);
      end
      c_hold--;
      bus.sensor_raw = raw;
      bus.country = ctry;
      m_step(raw, ctry);
      @(posedge clk);
      #1;
      chk("rnd_x", int'(bus.x), int'(m_x));
      chk("rnd_cnt", int'(bus.veh_count), m_cnt);
      chk("rnd_to", int'(bus.timeout), int'(m_to));
      chk("rnd_fault", int'(bus.sensor_fault), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
